// File: rtl/module_sensor_luz_spi.sv
// SPI master (mode 3, 16-clock frame) for the 8-bit ambient-light ADC.
// Runs one conversion every SAMPLE_PERIOD cycles while enabled and strobes each result.
module module_sensor_luz_spi #(
  parameter int unsigned CLK_DIV       = 13,
  parameter int unsigned SAMPLE_PERIOD = 100000,
  parameter int unsigned FRAME_BITS    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_clk_luz_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       cs_o,
  output logic [7:0] dato_luz_o,
  output logic       proccess_luz_o,
  output logic       busy_o
);

  localparam int unsigned TW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DW = $clog2(CLK_DIV + 1);
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_ALL   = BW'(FRAME_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DW-1:0]         div_q, div_d;
  logic [BW-1:0]         bits_q, bits_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic [7:0]            dato_q, dato_d;
  logic                  proc_q, proc_d;
  logic                  timer_expired;
  logic                  div_done;

  assign timer_expired = (timer_q == TIMER_LAST);
  assign div_done      = (div_q == DIV_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      div_q   <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b1;
      cs_q    <= 1'b1;
      dato_q  <= '0;
      proc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      dato_q  <= dato_d;
      proc_q  <= proc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    dato_d  = dato_q;
    proc_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (en_clk_luz_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!en_clk_luz_i) begin
          state_d = S_IDLE;
        end else if (timer_expired) begin
          state_d = S_CS_SETUP;
          cs_d    = 1'b0;
          div_d   = '0;
          bits_d  = '0;
          shreg_d = '0;
        end
      end
      S_CS_SETUP: begin
        if (div_done) begin
          state_d = S_SHIFT;
          div_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (!div_done) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          // Sample on the same edge that raises sclk_o; the last high phase runs full length.
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[FRAME_BITS-2:0], miso_i};
            bits_d  = bits_q + 1'b1;
          end else if (bits_q == BITS_ALL) begin
            state_d = S_CS_HOLD;
          end else begin
            sclk_d = 1'b0;
          end
        end
      end
      S_CS_HOLD: begin
        if (div_done) begin
          state_d = S_DONE;
          div_d   = '0;
          cs_d    = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        dato_d  = shreg_q[12:5];
        proc_d  = en_clk_luz_i;
        state_d = en_clk_luz_i ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer free-runs through the frame so strobe spacing stays exactly SAMPLE_PERIOD.
  always_comb begin
    if (state_q == S_IDLE || state_d == S_IDLE || timer_expired) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  assign sclk_o         = sclk_q;
  assign cs_o           = cs_q;
  assign dato_luz_o     = dato_q;
  assign proccess_luz_o = proc_q;
  assign busy_o         = ~cs_q;

endmodule

// File: tb/tb_module_sensor_luz_spi.sv
// Randomized self-checking bench for module_sensor_luz_spi against a frame-level model
// of the sensor and of the conversion schedule.
module tb_module_sensor_luz_spi;

  localparam int CD  = 3;
  localparam int SP  = 200;
  localparam int FB  = 16;
  localparam int LAT = 2 + CD * (2 + 2 * FB);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       miso = 1'b0;
  logic       sclk_o, cs_o, proccess_luz_o, busy_o;
  logic [7:0] dato_luz_o;

  module_sensor_luz_spi #(
    .CLK_DIV       (CD),
    .SAMPLE_PERIOD (SP),
    .FRAME_BITS    (FB)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .en_clk_luz_i   (en),
    .miso_i         (miso),
    .sclk_o         (sclk_o),
    .cs_o           (cs_o),
    .dato_luz_o     (dato_luz_o),
    .proccess_luz_o (proccess_luz_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sensor model: one 16-bit word per frame, MSB first, changes on sclk falling edges.
  logic [15:0] words [16];
  logic [7:0]  exp_bytes [16];
  logic [15:0] cur = '0;
  int          frames_started = 0;
  int          rises = 0;
  int          rises_log [16];
  logic        s_cs = 1'b1;
  logic        s_sclk = 1'b1;

  always @(cs_o or sclk_o) begin
    if (cs_o !== s_cs) begin
      if (!cs_o) begin
        cur = words[frames_started % 16];
        frames_started++;
        rises = 0;
        miso = cur[15];
      end else begin
        rises_log[(frames_started - 1) % 16] = rises;
      end
    end
    if (sclk_o !== s_sclk && !cs_o) begin
      if (sclk_o) rises++;
      else if (rises < 16) miso = cur[15 - rises];
    end
    s_cs = cs_o;
    s_sclk = sclk_o;
  end

  // Output monitor: strobe log and SCLK/CS protocol timing.
  int   stb_cyc [64];
  int   stb_val [64];
  int   n_stb = 0;
  int   run = 0;
  int   phase_ok = 0, phase_err = 0, hold_err = 0, idle_err = 0, busy_err = 0, long_err = 0;
  logic prev_s = 1'b1, prev_c = 1'b1, prev_p = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (proccess_luz_o) begin
        if (n_stb < 64) begin
          stb_cyc[n_stb] = cyc;
          stb_val[n_stb] = int'(dato_luz_o);
        end
        n_stb++;
        if (prev_p) long_err++;
      end
      if (sclk_o !== prev_s || cs_o !== prev_c) begin
        if (sclk_o !== prev_s && !cs_o && !prev_c) begin
          phase_ok++;
          if (run != CD) phase_err++;
        end
        if (cs_o && !prev_c && sclk_o && prev_s && run != 2 * CD) hold_err++;
        run = 1;
      end else begin
        run++;
      end
      if (cs_o && !sclk_o) idle_err++;
      if (busy_o !== !cs_o) busy_err++;
    end else begin
      run = 1;
    end
    prev_s = sclk_o;
    prev_c = cs_o;
    prev_p = proccess_luz_o;
  end

  function automatic logic [15:0] make_word(input logic [7:0] b, input int noise);
    logic [2:0] lead;
    logic [3:0] trail;
    logic       x;
    case (noise)
      0:       begin lead = '0; trail = '0; x = 1'b0; end
      1:       begin lead = 3'($urandom); trail = 4'($urandom); x = 1'($urandom); end
      default: begin lead = '1; trail = '1; x = 1'b1; end
    endcase
    return {lead, b, trail, x};
  endfunction

  // Enable, collect n strobes, drop enable; expect strobe i at enable + SP + LAT + i*SP.
  task automatic run_batch(input string name, input int n, input int noise);
    int base, s0, t_en, k;
    base = frames_started;
    s0 = n_stb;
    for (int i = 0; i < n; i++) words[(base + i) % 16] = make_word(exp_bytes[i], noise);
    en = 1'b1;
    t_en = cyc;
    k = 0;
    while (n_stb < s0 + n && k < n * SP + LAT + SP) begin
      @(posedge clk); #1;
      k++;
    end
    en = 1'b0;
    check({name, "_count"}, n_stb - s0, n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_val%0d", name, i), stb_val[s0 + i], int'(exp_bytes[i]));
      check($sformatf("%s_time%0d", name, i), stb_cyc[s0 + i], t_en + SP + LAT + i * SP);
      check($sformatf("%s_edges%0d", name, i), rises_log[(base + i) % 16], FB);
    end
    repeat (SP + LAT) @(posedge clk);
    #1;
    check({name, "_no_extra"}, n_stb - s0, n);
  endtask

  task automatic wait_mid_frame(input int fs, input int edges);
    int k;
    k = 0;
    while (!(frames_started == fs + 1 && rises >= edges) && k < SP + LAT) begin
      @(posedge clk); #1;
      k++;
    end
    check("mid_frame_reached", int'(frames_started == fs + 1 && rises >= edges), 1);
  endtask

  initial begin
    int s0, fs, k;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      words[i] = '0;
      rises_log[i] = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", int'(cs_o), 1);
    check("rst_sclk", int'(sclk_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_dato", int'(dato_luz_o), 0);
    check("rst_strobe", int'(proccess_luz_o), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    exp_bytes[0] = 8'hA5;
    run_batch("single", 1, 0);

    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'h3C;
    exp_bytes[3] = 8'h81; exp_bytes[4] = 8'h7E;
    run_batch("periodic", 5, 0);

    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'hFF;
    run_batch("noise_edge", 2, 2);

    for (int i = 0; i < 6; i++) exp_bytes[i] = 8'($urandom);
    run_batch("random", 6, 1);

    // Enable dropped after the 8th rising edge: frame completes, data lands, no strobe.
    b = 8'($urandom);
    fs = frames_started;
    words[fs % 16] = make_word(b, 1);
    s0 = n_stb;
    en = 1'b1;
    wait_mid_frame(fs, 8);
    en = 1'b0;
    k = 0;
    while (!cs_o && k < LAT) begin
      @(posedge clk); #1;
      k++;
    end
    check("drop_cs_release", int'(cs_o), 1);
    repeat (3) @(posedge clk);
    #1;
    check("drop_no_strobe", n_stb - s0, 0);
    check("drop_data", int'(dato_luz_o), int'(b));
    check("drop_edges", rises_log[fs % 16], FB);
    repeat (SP + LAT) @(posedge clk);
    #1;
    check("drop_idle", frames_started - fs, 1);

    // Reset asserted mid-SHIFT.
    fs = frames_started;
    words[fs % 16] = make_word(8'h5A, 1);
    s0 = n_stb;
    en = 1'b1;
    wait_mid_frame(fs, 4);
    rst_n = 1'b0;
    #1;
    check("midrst_cs", int'(cs_o), 1);
    check("midrst_sclk", int'(sclk_o), 1);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_dato", int'(dato_luz_o), 0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (SP + LAT + 10) @(posedge clk);
    #1;
    check("midrst_no_strobe", n_stb - s0, 0);
    check("midrst_no_frame", frames_started - fs, 1);

    exp_bytes[0] = 8'($urandom);
    run_batch("recover", 1, 1);

    check("sclk_phase_err", phase_err, 0);
    check("sclk_phases_seen", int'(phase_ok >= 16 * 2 * 15), 1);
    check("cs_hold_err", hold_err, 0);
    check("sclk_idle_err", idle_err, 0);
    check("busy_err", busy_err, 0);
    check("strobe_width_err", long_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
